// File: rtl/stack_cpu_core.sv
`timescale 1ns/1ps
// stack_cpu_core
//   Multi-cycle stack-machine core. The control FSM fetches instructions from a
//   single req/ack memory port, decodes them against the current stack
//   occupancy, and executes ALU, PUSH/POP and jump instructions. Stack
//   overflow/underflow traps into a sticky FAULT state that only reset clears.
//   Instruction word: opcode in [DATA_W-1 -: 3], operand address in [ADDR_W-1:0].
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous, active-low
//   run        : start/continue execution (sampled at instruction boundaries)
//   mem_req    : registered memory request, held until mem_ack
//   mem_we     : 1 = write, 0 = read; stable while mem_req
//   mem_addr   : memory address; stable while mem_req
//   mem_wdata  : write data; stable while mem_req
//   mem_rdata  : read data, valid in the ack cycle
//   mem_ack    : transfer completes this cycle
//   busy       : high in every state except IDLE and FAULT
//   pc         : program counter
//   sp         : stack occupancy (0 = empty)
//   z          : stack non-empty and top of stack is zero
//   fault      : sticky fault flag
//   fault_code : 2'b01 underflow, 2'b10 overflow, 2'b00 none
module stack_cpu_core #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 5,
  parameter int STACK_DEPTH = 16,
  localparam int SPW        = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] pc,
  output logic [SPW-1:0]    sp,
  output logic              z,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam int IDXW = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM_RD = 3'd4,
    S_MEM_WR = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [SPW-1:0]     sp_q, sp_d;
  logic [DATA_W-1:0]  ir_q, ir_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               fault_q, fault_d;
  logic [1:0]         fault_code_q, fault_code_d;

  logic [DATA_W-1:0]  stack_q [STACK_DEPTH];
  logic               stk_we;
  logic [IDXW-1:0]    stk_widx;
  logic [DATA_W-1:0]  stk_wdata;

  logic [2:0]         opcode;
  logic [ADDR_W-1:0]  operand;
  logic [IDXW-1:0]    tos_idx, nos_idx;
  logic [DATA_W-1:0]  tos, nos, alu_res;
  logic               xfer, underflow, overflow;

  assign opcode  = ir_q[DATA_W-1 -: 3];
  assign operand = ir_q[ADDR_W-1:0];
  // TOS lives at entry sp-1, its neighbour at sp-2; only meaningful when the
  // occupancy check in DECODE has already passed.
  assign tos_idx = IDXW'(sp_q - SPW'(1));
  assign nos_idx = IDXW'(sp_q - SPW'(2));
  assign tos     = stack_q[tos_idx];
  assign nos     = stack_q[nos_idx];
  // An ack only counts while our registered request is actually up.
  assign xfer    = mem_req_q & mem_ack;

  // Stack occupancy requirement for the decoded opcode.
  always_comb begin
    underflow = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND: underflow = (sp_q < SPW'(2));
      OP_NOT, OP_POP, OP_JZ:  underflow = (sp_q == {SPW{1'b0}});
      default:                underflow = 1'b0;
    endcase
  end

  assign overflow = (opcode == OP_PUSH) && (sp_q >= SPW'(STACK_DEPTH));

  // ALU result; carries are discarded by the DATA_W-wide result.
  always_comb begin
    alu_res = tos;
    case (opcode)
      OP_ADD:  alu_res = nos + tos;
      OP_SUB:  alu_res = nos - tos;
      OP_AND:  alu_res = nos & tos;
      OP_NOT:  alu_res = ~tos;
      default: alu_res = tos;
    endcase
  end

  // Control state and architectural registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= {ADDR_W{1'b0}};
      sp_q         <= {SPW{1'b0}};
      ir_q         <= {DATA_W{1'b0}};
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_wdata_q  <= {DATA_W{1'b0}};
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      sp_q         <= sp_d;
      ir_q         <= ir_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Stack storage; contents survive reset, only sp is cleared.
  always_ff @(posedge clk) begin
    if (stk_we) begin
      stack_q[stk_widx] <= stk_wdata;
    end
  end

  // Next-state logic of the control FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
        else     state_d = S_IDLE;
      end
      S_FETCH: begin
        if (xfer) state_d = S_DECODE;
        else      state_d = S_FETCH;
      end
      S_DECODE: begin
        if (underflow || overflow) begin
          state_d = S_FAULT;
        end else begin
          case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_NOT: state_d = S_EXEC;
            OP_PUSH:                        state_d = S_MEM_RD;
            OP_POP:                         state_d = S_MEM_WR;
            default:                        state_d = run ? S_FETCH : S_IDLE;
          endcase
        end
      end
      S_EXEC: state_d = run ? S_FETCH : S_IDLE;
      S_MEM_RD, S_MEM_WR: begin
        if (xfer) state_d = run ? S_FETCH : S_IDLE;
        else      state_d = state_q;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: pc, sp, IR, fault status and stack writes.
  always_comb begin
    pc_d         = pc_q;
    sp_d         = sp_q;
    ir_d         = ir_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;
    stk_we       = 1'b0;
    stk_widx     = {IDXW{1'b0}};
    stk_wdata    = {DATA_W{1'b0}};
    case (state_q)
      S_FETCH: begin
        if (xfer) begin
          ir_d = mem_rdata;
          pc_d = pc_q + ADDR_W'(1);
        end else begin
          ir_d = ir_q;
          pc_d = pc_q;
        end
      end
      S_DECODE: begin
        // Trap checks come first so a faulting instruction changes nothing else.
        if (underflow) begin
          fault_d      = 1'b1;
          fault_code_d = 2'b01;
        end else if (overflow) begin
          fault_d      = 1'b1;
          fault_code_d = 2'b10;
        end else if (opcode == OP_JMP) begin
          pc_d = operand;
        end else if ((opcode == OP_JZ) && (tos == {DATA_W{1'b0}})) begin
          pc_d = operand;
        end else begin
          pc_d = pc_q;
        end
      end
      S_EXEC: begin
        stk_we    = 1'b1;
        stk_wdata = alu_res;
        if (opcode == OP_NOT) begin
          stk_widx = tos_idx;
          sp_d     = sp_q;
        end else begin
          stk_widx = nos_idx;
          sp_d     = sp_q - SPW'(1);
        end
      end
      S_MEM_RD: begin
        if (xfer) begin
          stk_we    = 1'b1;
          stk_widx  = sp_q[IDXW-1:0];
          stk_wdata = mem_rdata;
          sp_d      = sp_q + SPW'(1);
        end else begin
          stk_we = 1'b0;
        end
      end
      S_MEM_WR: begin
        if (xfer) sp_d = sp_q - SPW'(1);
        else      sp_d = sp_q;
      end
      default: sp_d = sp_q;
    endcase
  end

  // Memory request registers. The request is raised for the state being
  // entered, drops for one cycle after every ack, and its address/data are
  // computed only from values that stay constant until the ack.
  always_comb begin
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_d)
      S_FETCH: begin
        mem_req_d  = ~xfer;
        mem_we_d   = 1'b0;
        mem_addr_d = pc_d;
      end
      S_MEM_RD: begin
        mem_req_d  = ~xfer;
        mem_we_d   = 1'b0;
        mem_addr_d = operand;
      end
      S_MEM_WR: begin
        mem_req_d   = ~xfer;
        mem_we_d    = 1'b1;
        mem_addr_d  = operand;
        mem_wdata_d = tos;
      end
      default: mem_req_d = 1'b0;
    endcase
  end

  // Output decode of the control FSM.
  always_comb begin
    busy = 1'b0;
    case (state_q)
      S_IDLE, S_FAULT: busy = 1'b0;
      default:         busy = 1'b1;
    endcase
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign pc         = pc_q;
  assign sp         = sp_q;
  assign z          = (sp_q != {SPW{1'b0}}) && (tos == {DATA_W{1'b0}});
  assign fault      = fault_q;
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_stack_cpu_core.sv
`timescale 1ns/1ps
module tb_stack_cpu_core;
  localparam int DW  = 8;
  localparam int AW  = 5;
  localparam int SD  = 4;
  localparam int SPW = $clog2(SD + 1);

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           run = 1'b0;
  logic           mem_ack = 1'b0;
  logic [DW-1:0]  mem_rdata = '0;
  logic           mem_req, mem_we, busy, z, fault;
  logic [AW-1:0]  mem_addr, pc;
  logic [DW-1:0]  mem_wdata;
  logic [SPW-1:0] sp;
  logic [1:0]     fault_code;

  always #5 clk = ~clk;

  stack_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .pc(pc), .sp(sp), .z(z), .fault(fault), .fault_code(fault_code)
  );

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [AW-1:0] pc; logic [SPW-1:0] sp; logic z; logic fault; logic [1:0] code; } st_t;

  wr_t wq[$];
  st_t sq[$];
  wr_t w_m;
  st_t s_m;

  int n_pass = 0, n_total = 0;
  int unexp_wr = 0, unexp_end = 0, unstable = 0;
  int cyc = 0, t2 = -1, t3 = -1;
  bit mon_en = 1'b1;

  logic [DW-1:0] mem [32];
  int ack_delay = 0, wait_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic exp_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.addr = a; w.data = d;
    wq.push_back(w);
  endtask

  task automatic exp_state(input logic [AW-1:0] p, input logic [SPW-1:0] s, input logic zz,
                           input logic f, input logic [1:0] c);
    st_t e;
    e.pc = p; e.sp = s; e.z = zz; e.fault = f; e.code = c;
    sq.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic load_add_prog(input logic [DW-1:0] alu_op);
    clear_mem();
    mem[0] = 8'h9E; mem[1] = 8'h9F; mem[2] = alu_op; mem[3] = 8'hBD;
    mem[30] = 8'h05; mem[31] = 8'hFE;
  endtask

  task automatic do_reset();
    @(negedge clk);
    run = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs from reset with run=1, drops run once the fetch of last_addr is acked,
  // then waits for the core to go idle/fault and checks the scoreboard drained.
  task automatic run_prog(input logic [AW-1:0] last_addr, input int dly);
    bit seen;
    ack_delay = dly;
    do_reset();
    t2 = -1; t3 = -1; unexp_wr = 0; unexp_end = 0; unstable = 0;
    run = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (mem_req && mem_ack && !mem_we && mem_addr == last_addr) begin
        run = 1'b0;
        seen = 1'b1;
      end
    end
    chk("last_fetch_reached", {31'd0, seen}, 32'd1);
    for (int k = 0; k < 400 && busy !== 1'b0; k++) @(negedge clk);
    chk("idle_reached", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    chk("writes_drained", wq.size(), 32'd0);
    chk("states_drained", sq.size(), 32'd0);
    chk("unexpected_writes", unexp_wr, 32'd0);
    chk("unexpected_idle", unexp_end, 32'd0);
    chk("req_stability", unstable, 32'd0);
  endtask

  // Memory model: answers each request after ack_delay wait cycles.
  always @(posedge clk) begin
    #2;
    if (mem_req === 1'b1 && wait_cnt >= ack_delay) begin
      mem_ack = 1'b1;
      mem_rdata = mem[mem_addr];
      if (mem_we) mem[mem_addr] = mem_wdata;
      wait_cnt = 0;
    end else if (mem_req === 1'b1) begin
      mem_ack = 1'b0;
      wait_cnt++;
    end else begin
      mem_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  always @(posedge clk) cyc++;

  // Monitor: pops expected writes on write acks and expected end states when busy falls.
  logic           busy_prev = 1'b0, req_prev = 1'b0, ack_prev = 1'b0, we_prev = 1'b0;
  logic [AW-1:0]  addr_prev = '0;
  logic [DW-1:0]  wdata_prev = '0;
  always @(negedge clk) begin
    if (mem_req === 1'b1 && mem_ack === 1'b1 && mem_we === 1'b1) begin
      if (wq.size() == 0) unexp_wr++;
      else begin
        w_m = wq.pop_front();
        chk("write_addr", {27'd0, mem_addr}, {27'd0, w_m.addr});
        chk("write_data", {24'd0, mem_wdata}, {24'd0, w_m.data});
      end
    end
    if (mon_en && busy_prev === 1'b1 && busy === 1'b0) begin
      if (sq.size() == 0) unexp_end++;
      else begin
        s_m = sq.pop_front();
        chk("end_pc", {27'd0, pc}, {27'd0, s_m.pc});
        chk("end_sp", {29'd0, sp}, {29'd0, s_m.sp});
        chk("end_z", {31'd0, z}, {31'd0, s_m.z});
        chk("end_fault", {31'd0, fault}, {31'd0, s_m.fault});
        chk("end_fault_code", {30'd0, fault_code}, {30'd0, s_m.code});
      end
    end
    if (req_prev === 1'b1 && mem_req === 1'b1 && ack_prev === 1'b0 &&
        (mem_addr !== addr_prev || mem_we !== we_prev || mem_wdata !== wdata_prev))
      unstable++;
    if (mem_req === 1'b1 && req_prev === 1'b0 && mem_we === 1'b0) begin
      if (mem_addr == 5'd2) t2 = cyc;
      if (mem_addr == 5'd3) t3 = cyc;
    end
    busy_prev = busy; req_prev = mem_req; ack_prev = mem_ack;
    we_prev = mem_we; addr_prev = mem_addr; wdata_prev = mem_wdata;
  end

  initial begin
    bit hit;
    clear_mem();

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_pc", {27'd0, pc}, 32'd0);
    chk("rst_sp", {29'd0, sp}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_fault_code", {30'd0, fault_code}, 32'd0);

    // PUSH 5, PUSH FE, ADD -> 0x103 mod 256 = 0x03, POP to 29
    load_add_prog(8'h00);
    exp_write(5'd29, 8'h03);
    exp_state(5'd4, 3'd0, 1'b0, 1'b0, 2'b00);
    run_prog(5'd3, 0);
    chk("add_mem29", {24'd0, mem[29]}, 32'h03);
    chk("add_latency_zero_wait", t3 - t2, 32'd3);

    // SUB: 5 - FE = 0x07
    load_add_prog(8'h20);
    exp_write(5'd29, 8'h07);
    exp_state(5'd4, 3'd0, 1'b0, 1'b0, 2'b00);
    run_prog(5'd3, 0);
    chk("sub_mem29", {24'd0, mem[29]}, 32'h07);

    // ADD on an empty stack -> underflow, no write
    clear_mem();
    mem[0] = 8'h00;
    exp_state(5'd1, 3'd0, 1'b0, 1'b1, 2'b01);
    run_prog(5'd0, 0);

    // Five pushes into a 4-deep stack -> overflow on the fifth DECODE
    clear_mem();
    for (int i = 0; i < 5; i++) mem[i] = 8'h9E;
    mem[30] = 8'h05;
    exp_state(5'd5, 3'd4, 1'b0, 1'b1, 2'b10);
    run_prog(5'd4, 0);
    // Fault is sticky: run again has no effect
    run = 1'b1;
    repeat (5) @(negedge clk);
    chk("sticky_fault", {31'd0, fault}, 32'd1);
    chk("sticky_pc", {27'd0, pc}, 32'd5);
    chk("sticky_req", {31'd0, mem_req}, 32'd0);
    run = 1'b0;

    // JZ taken (TOS == 0)
    clear_mem();
    mem[0] = 8'h9E; mem[1] = 8'hF4; mem[30] = 8'h00;
    exp_state(5'd20, 3'd1, 1'b1, 1'b0, 2'b00);
    run_prog(5'd1, 0);

    // JZ not taken (TOS == 1)
    mem[30] = 8'h01;
    exp_state(5'd2, 3'd1, 1'b0, 1'b0, 2'b00);
    run_prog(5'd1, 0);

    // Three wait cycles on every transfer
    load_add_prog(8'h00);
    exp_write(5'd29, 8'h03);
    exp_state(5'd4, 3'd0, 1'b0, 1'b0, 2'b00);
    run_prog(5'd3, 3);
    chk("wait_mem29", {24'd0, mem[29]}, 32'h03);
    chk("add_latency_wait3", t3 - t2, 32'd6);

    // Reset in the middle of a waiting PUSH read
    mon_en = 1'b0;
    load_add_prog(8'h00);
    ack_delay = 3;
    do_reset();
    run = 1'b1;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_ack === 1'b0 && mem_addr == 5'd30) hit = 1'b1;
    end
    chk("wait_reached", {31'd0, hit}, 32'd1);
    chk("pc_before_reset", {27'd0, pc}, 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_pc", {27'd0, pc}, 32'd0);
    chk("midrst_sp", {29'd0, sp}, 32'd0);
    @(negedge clk);
    run = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
